// File: rtl/core_seq_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
// One request at a time; a transfer completes on an edge with mem_req & mem_ack.
interface core_seq_if;
    logic       mem_req;
    logic       mem_is_fetch;
    logic       mem_we;
    logic [3:0] mem_wmask;
    logic       mem_ack;

    modport master (
        output mem_req, mem_is_fetch, mem_we, mem_wmask,
        input  mem_ack
    );

    modport slave (
        input  mem_req, mem_is_fetch, mem_we, mem_wmask,
        output mem_ack
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle miniRV sequencer: FETCH/DECODE/EXEC/MEM/WB with sticky HALT/ERROR,
// arbitrates the single memory port by state and traps on an ack timeout.
module core_seq #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_jump,
    input  logic        dec_rd_we,
    input  logic        dec_ebreak,
    input  logic        dec_illegal,
    input  logic [3:0]  dec_wbmask,
    core_seq_if.master  mem,
    output logic        ir_we,
    output logic        rdata_we,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        halted,
    output logic        error,
    output logic [31:0] instret
);

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] instret_q, instret_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // The wait counter only runs while a request is outstanding, so every
    // entry into FETCH or MEM starts from zero.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        instret_d = instret_q;
        case (state_q)
            S_FETCH: begin
                if (mem.mem_ack) begin
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == TMO) state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                if (dec_illegal)     state_d = S_ERROR;
                else if (dec_ebreak) state_d = S_HALT;
                else                 state_d = S_EXEC;
            end
            S_EXEC: state_d = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem.mem_ack) begin
                    state_d = S_WB;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == TMO) state_d = S_ERROR;
                end
            end
            S_WB: begin
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // Outputs are forced low while reset is held so an aborted request drops
    // asynchronously, without waiting for the state register.
    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_is_fetch = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_wmask    = 4'b0000;
        ir_we            = 1'b0;
        rdata_we         = 1'b0;
        rf_we            = 1'b0;
        rf_wsel          = 2'd0;
        pc_we            = 1'b0;
        pc_sel           = 1'b0;
        halted           = 1'b0;
        error            = 1'b0;
        if (reset_n) begin
            case (state_q)
                S_FETCH: begin
                    mem.mem_req      = 1'b1;
                    mem.mem_is_fetch = 1'b1;
                    ir_we            = mem.mem_ack;
                end
                S_MEM: begin
                    mem.mem_req   = 1'b1;
                    mem.mem_we    = dec_is_store;
                    mem.mem_wmask = dec_is_store ? dec_wbmask : 4'b0000;
                    rdata_we      = mem.mem_ack & dec_is_load;
                end
                S_WB: begin
                    rf_we   = dec_rd_we & ~dec_is_store;
                    rf_wsel = dec_is_jump ? 2'd2 : (dec_is_load ? 2'd1 : 2'd0);
                    pc_we   = 1'b1;
                    pc_sel  = dec_is_jump;
                end
                S_HALT:  halted = 1'b1;
                S_ERROR: begin
                    halted = 1'b1;
                    error  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq (ACK_TIMEOUT=4): ALU, store with waits, load+jump,
// ebreak halt, reset during a store wait, and ack timeout to ERROR.
module tb_core_seq;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        dec_is_load, dec_is_store, dec_is_jump, dec_rd_we;
    logic        dec_ebreak, dec_illegal;
    logic [3:0]  dec_wbmask;
    logic        ir_we, rdata_we, rf_we, pc_we, pc_sel, halted, error;
    logic [1:0]  rf_wsel;
    logic [31:0] instret;
    int          passed = 0;
    int          total  = 0;

    core_seq_if mif ();

    core_seq #(.ACK_TIMEOUT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_is_jump(dec_is_jump), .dec_rd_we(dec_rd_we),
        .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
        .dec_wbmask(dec_wbmask), .mem(mif),
        .ir_we(ir_we), .rdata_we(rdata_we), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .error(error),
        .instret(instret)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic jp, input logic rd,
                           input logic eb, input logic il, input logic [3:0] mask);
        dec_is_load = ld; dec_is_store = st; dec_is_jump = jp; dec_rd_we = rd;
        dec_ebreak = eb; dec_illegal = il; dec_wbmask = mask;
    endtask

    initial begin
        reset_n = 1'b0;
        mif.mem_ack = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 4'b0000);

        // reset state: everything low, even with ack asserted
        repeat (2) tick();
        mif.mem_ack = 1'b1; #1;
        chk("rst_req", mif.mem_req, 0);
        chk("rst_ir_we", ir_we, 0);
        chk("rst_instret", instret, 0);
        chk("rst_halted", halted, 0);
        mif.mem_ack = 1'b0;
        reset_n = 1'b1; #1;
        chk("post_rst_req", mif.mem_req, 1);
        chk("post_rst_fetch", mif.mem_is_fetch, 1);

        // ALU, zero wait: FETCH DECODE EXEC WB
        tick();
        set_dec(0, 0, 0, 1, 0, 0, 4'b0000);
        mif.mem_ack = 1'b1; #1;
        chk("alu_ir_we", ir_we, 1);
        chk("alu_fetch_we", mif.mem_we, 0);
        tick();
        chk("alu_dec_req", mif.mem_req, 0);
        chk("alu_dec_ir_we", ir_we, 0);
        tick();
        chk("alu_exec_pc_we", pc_we, 0);
        tick();
        chk("alu_wb_rf_we", rf_we, 1);
        chk("alu_wb_wsel", rf_wsel, 0);
        chk("alu_wb_pc_we", pc_we, 1);
        chk("alu_wb_pc_sel", pc_sel, 0);
        chk("alu_wb_instret", instret, 0);
        tick();
        chk("alu_instret", instret, 1);
        chk("alu_next_fetch", mif.mem_is_fetch, 1);

        // store, mask 0011, two wait cycles in MEM: 7 cycles
        set_dec(0, 1, 0, 1, 0, 0, 4'b0011);
        tick();
        chk("st_dec_req", mif.mem_req, 0);
        tick();
        mif.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) mif.mem_ack = 1'b1;
            #1;
            chk("st_mem_req", mif.mem_req, 1);
            chk("st_mem_fetch", mif.mem_is_fetch, 0);
            chk("st_mem_we", mif.mem_we, 1);
            chk("st_mem_mask", mif.mem_wmask, 4'b0011);
            chk("st_rdata_we", rdata_we, 0);
        end
        tick();
        chk("st_wb_req", mif.mem_req, 0);
        chk("st_wb_rf_we", rf_we, 0);
        chk("st_wb_pc_we", pc_we, 1);
        tick();
        chk("st_instret", instret, 2);

        // load then jalr
        set_dec(1, 0, 0, 1, 0, 0, 4'b1111);
        tick(); tick(); tick();
        chk("ld_mem_req", mif.mem_req, 1);
        chk("ld_mem_we", mif.mem_we, 0);
        chk("ld_mem_mask", mif.mem_wmask, 0);
        chk("ld_rdata_we", rdata_we, 1);
        tick();
        chk("ld_wb_rf_we", rf_we, 1);
        chk("ld_wb_wsel", rf_wsel, 1);
        chk("ld_wb_pc_sel", pc_sel, 0);
        chk("ld_wb_rdata_we", rdata_we, 0);
        tick();
        set_dec(0, 0, 1, 1, 0, 0, 4'b0000);
        tick(); tick(); tick();
        chk("jp_wb_rf_we", rf_we, 1);
        chk("jp_wb_wsel", rf_wsel, 2);
        chk("jp_wb_pc_sel", pc_sel, 1);
        tick();
        chk("jp_instret", instret, 4);

        // ebreak: sticky halt, ack ignored
        set_dec(0, 0, 0, 0, 1, 0, 4'b0000);
        tick();
        tick();
        chk("eb_halted", halted, 1);
        chk("eb_error", error, 0);
        for (int i = 0; i < 20; i++) begin
            mif.mem_ack = i[0]; #1;
            chk("eb_no_req", mif.mem_req, 0);
            chk("eb_no_ir_we", ir_we, 0);
            tick();
        end
        chk("eb_still_halted", halted, 1);
        chk("eb_instret", instret, 4);

        // reset pulled mid-MEM store wait
        reset_n = 1'b0; #1;
        chk("rst2_halted", halted, 0);
        chk("rst2_instret", instret, 0);
        reset_n = 1'b1;
        set_dec(0, 1, 0, 0, 0, 0, 4'b1111);
        mif.mem_ack = 1'b1;
        tick(); tick(); tick();
        mif.mem_ack = 1'b0; #1;
        chk("rst3_mem_we", mif.mem_we, 1);
        chk("rst3_mem_req", mif.mem_req, 1);
        #2 reset_n = 1'b0; #1;
        chk("rst3_req_drop", mif.mem_req, 0);
        chk("rst3_we_drop", mif.mem_we, 0);
        tick();
        chk("rst3_held_pc_we", pc_we, 0);
        reset_n = 1'b1; #1;
        chk("rst3_fetch_req", mif.mem_req, 1);
        chk("rst3_fetch_sel", mif.mem_is_fetch, 1);
        chk("rst3_instret", instret, 0);
        chk("rst3_error", error, 0);

        // timeout: ack tied low, request held 4 cycles then ERROR
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("tmo_req_held", mif.mem_req, 1);
            chk("tmo_no_error", error, 0);
        end
        tick();
        chk("tmo_error", error, 1);
        chk("tmo_halted", halted, 1);
        chk("tmo_req_off", mif.mem_req, 0);
        mif.mem_ack = 1'b1;
        repeat (3) tick();
        chk("tmo_sticky", error, 1);
        chk("tmo_instret", instret, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
